seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Runtime-programmable serial bit-pattern detector with a saturating match counter. It is the generalised successor to the fixed 3-bit detector FSM. It adds:
- pattern length up to MAX_W bits;
- selectable overlapping or non-overlapping detection;
- a sample-enable qualifier;
- a counter clear and a sticky saturation flag.

It sits on a 1-bit serial stream (framing/sync-word search) and reports match pulses and counts to control logic.

Parameters:
- MAX_W, 8, maximum pattern length in bits (2..16).
- COUNT_W, 10, match counter width.
- DEF_PATTERN, 8'b0000_0010, pattern loaded at reset, right-aligned.
- DEF_LEN, 3, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.
- LEN_W, $clog2(MAX_W+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; x is consumed on a rising edge only when en=1.
- x  in  1  serial data bit.
- cfg_load  in  1  1-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_W  pattern, right-aligned; bit [len-1] is the oldest bit, bit [0] the newest.
- cfg_len  in  LEN_W  pattern length; legal range is 1..MAX_W.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of count and count_sat.
- match  out  1  registered 1-cycle pulse per detected pattern.
- count  out  COUNT_W  number of matches, saturating.
- count_sat  out  1  sticky flag, high once count has saturated.
- cfg_err  out  1  high while the latched length is illegal.

Behaviour:

Reset (rst=1, async):
- hist = 0, fill = 0, match = 0, count = 0, count_sat = 0.
- Config registers = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
- cfg_err = (DEF_LEN==0 || DEF_LEN>MAX_W).
- Reset asserted mid-stream discards all partial history.

Internal state:
- hist[MAX_W-1:0]: shift register of received bits.
- fill[LEN_W-1:0]: count of valid history bits, saturating at MAX_W.

Accepted sample (en=1 and cfg_load=0):
- hist_n = {hist[MAX_W-2:0], x}.
- fill_n = min(fill+1, MAX_W).
- hit = !cfg_err && (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0]). Compare only the low len bits.
- On the same edge: hist <= hist_n and match <= hit.
  - If hit and overlap=1: fill <= fill_n.
  - If hit and overlap=0: fill <= 0, so the next match needs len fresh bits.
  - If no hit: fill <= fill_n.
- Latency: match is high in the cycle immediately after the edge that consumed the final pattern bit.

No accepted sample (en=0):
- hist and fill hold.
- match <= 0; match never holds for more than 1 cycle.

cfg_load=1:
- Latch cfg_pattern, cfg_len and cfg_overlap.
- hist <= 0, fill <= 0, match <= 0.
- cfg_err <= (cfg_len==0 || cfg_len>MAX_W).
- count and count_sat are unchanged.
- cfg_load has priority over en: a sample presented in the same cycle is dropped.

Counter:
- On a hit: if count == 2^COUNT_W-1, count holds and count_sat <= 1; otherwise count <= count+1.
- count updates on the same edge as match.
- clr_count=1: count <= 0 and count_sat <= 0. This has priority over a simultaneous hit increment; the match pulse still occurs.
- After a clear, count restarts from 0.

Illegal length (cfg_err=1):
- No matches and no count changes.
- hist and fill still shift.

Test Plan:
- Defaults (pattern 010, len 3, overlap 1), en=1, x = 0,1,0,1,0 -> match pulses after the 3rd and 5th bits; count=2.
- cfg_load pattern 010, len 3, overlap 0; x = 0,1,0,1,0 -> one match after the 3rd bit; count=1. Then x=0,1,0 -> match on the 3rd bit; count=2.
- cfg_load pattern 1101, len 4, overlap 1; x = 1,1,0,1,1,0,1 with en=0 gaps inserted between bits -> matches after bits 4 and 7 only; gaps have no effect; count=2.
- COUNT_W=2 override, overlap 1, pattern 1 (len 1), x=1 for 5 samples -> count = 1,2,3,3,3; count_sat=1 from the 4th hit. Then clr_count coincident with a hit -> count=0, count_sat=0, match=1.
- cfg_len=0 load -> cfg_err=1; any stream gives no match and count unchanged. Reload with len 3 -> cfg_err=0 and history is empty (the first two bits cannot match).
- Reset mid-stream after x=0,1 (pattern 010), then x=0 -> no match. x=1,0 -> match after the 2nd post-reset 0; all outputs 0 during reset.

Source files
------------

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Runtime-programmable serial pattern detector with overlap
//            control, sample qualifier and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               MAX_W       = 8,
    parameter int               COUNT_W     = 10,
    parameter logic [MAX_W-1:0] DEF_PATTERN = 8'b0000_0010,
    parameter int               DEF_LEN     = 3,
    parameter bit               DEF_OVERLAP = 1'b1,
    parameter int               LEN_W       = $clog2(MAX_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_W-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [COUNT_W-1:0] count,
    output logic               count_sat,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0]   c_max_fill  = LEN_W'(MAX_W);
    localparam logic [LEN_W-1:0]   c_def_len   = LEN_W'(DEF_LEN);
    localparam logic               c_def_err   = (DEF_LEN == 0) || (DEF_LEN > MAX_W);
    localparam logic [COUNT_W-1:0] c_count_max = {COUNT_W{1'b1}};

    logic [MAX_W-1:0]   r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match;
    logic [COUNT_W-1:0] r_count;
    logic               r_count_sat;
    logic [MAX_W-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_err;

    logic               w_sample;
    logic [MAX_W-1:0]   w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_W-1:0]   w_mask;
    logic               w_eq;
    logic               w_hit;

    // A sample presented together with a configuration load is dropped.
    assign w_sample = en && !cfg_load;
    assign w_hist_n = {r_hist[MAX_W-2:0], x};
    assign w_fill_n = (r_fill >= c_max_fill) ? c_max_fill : r_fill + 1'b1;

    // Only the newest r_len bits take part in the comparison.
    for (genvar i = 0; i < MAX_W; i++) begin : g_mask
        assign w_mask[i] = (r_len > LEN_W'(i));
    end

    assign w_eq  = ((w_hist_n ^ r_pattern) & w_mask) == '0;
    assign w_hit = w_sample && !r_cfg_err && (w_fill_n >= r_len) && w_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_pattern <= DEF_PATTERN;
            r_len     <= c_def_len;
            r_overlap <= DEF_OVERLAP;
            r_cfg_err <= c_def_err;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_cfg_err <= (cfg_len == '0) || (cfg_len > c_max_fill);
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else if (en) begin
            r_hist  <= w_hist_n;
            r_match <= w_hit;
            // Non-overlapping mode demands a full fresh pattern after a hit.
            r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_n;
        end else begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_count_sat <= 1'b0;
        end else if (clr_count) begin
            r_count     <= '0;
            r_count_sat <= 1'b0;
        end else if (w_hit) begin
            if (r_count == c_count_max) begin
                r_count_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign match     = r_match;
    assign count     = r_count;
    assign count_sat = r_count_sat;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
